sprite_hshrink_writer: RTL and testbench

//  Downstream of the fast-VRAM cycle stage. Consumes its 14-bit sprite parameter pipe output
//  {chain, hshrink[3:0], xpos[8:0]}.

---
 rtl/sprite_hshrink_writer_if.sv | 28 ++
 rtl/sprite_hshrink_writer.sv | 193 +++++++++++++++++++
 tb/tb_sprite_hshrink_writer.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_hshrink_writer_if.sv
// Sprite parameter input and line-buffer write bus for sprite_hshrink_writer.
//
// Handshake: there is no backpressure anywhere on this bus. SPR_LOAD is a
// one-cycle strobe that marks PIPE_C valid for that cycle only. PIX_WE is a
// one-cycle write strobe that qualifies PIX_ADDR/PIX_IDX in the same cycle.
// DONE is a one-cycle pulse. Consumers must accept every strobe as it comes.
interface sprite_hshrink_writer_if #(
    parameter int XW = 9
);
    logic          SPR_LOAD;
    logic [XW+4:0] PIPE_C;     // {chain, hshrink[3:0], xpos[XW-1:0]}
    logic          PIX_WE;
    logic [XW-1:0] PIX_ADDR;
    logic [3:0]    PIX_IDX;
    logic          DONE;

    // Upstream/downstream side: drives sprite parameters and observes writes.
    modport master (
        output SPR_LOAD, PIPE_C,
        input  PIX_WE, PIX_ADDR, PIX_IDX, DONE
    );

    // Writer side.
    modport slave (
        input  SPR_LOAD, PIPE_C,
        output PIX_WE, PIX_ADDR, PIX_IDX, DONE
    );
endinterface

// File: rtl/sprite_hshrink_writer.sv
// Sprite horizontal-shrink line-buffer writer.
// Takes one sprite parameter word, resolves chained X positions against the
// previous sprite on the line, then walks the 16 source pixels at pixel rate
// and emits a line-buffer write for every pixel kept by the shrink mask.
module sprite_hshrink_writer #(
    parameter int XW   = 9,
    parameter int NPIX = 16
) (
    input  logic                    CLK,
    input  logic                    RESETP,
    input  logic                    CLK_EN_PIX,
    input  logic                    NEW_LINE,
    sprite_hshrink_writer_if.slave  bus,
    output logic                    BUSY,
    output logic [XW-1:0]           XPOS,
    output logic                    LOAD_ERR,
    output logic [1:0]              STATE_DBG
);

    localparam int IW = $clog2(NPIX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [XW+4:0]   pipe_q;
    logic            pipe_chain;
    logic [3:0]      pipe_hs;
    logic [XW-1:0]   pipe_x;

    logic [XW-1:0]   prev_x;
    logic [XW-1:0]   prev_w;
    logic [XW-1:0]   addr;
    logic [XW-1:0]   xpos_q;
    logic [XW-1:0]   load_xpos;
    logic [IW-1:0]   idx;

    logic [15:0]     keep_mask;
    logic            keep_bit;
    logic            last_idx;
    logic            pix_step;
    logic            pix_we;
    logic            done_q;
    logic            load_err_q;

    // Keep mask per hshrink value; bit 15 is source pixel 0. popcount = hs+1.
    function automatic logic [15:0] shrink_mask(input logic [3:0] hs);
        logic [15:0] m;
        case (hs)
            4'd0:    m = 16'h0080;
            4'd1:    m = 16'h0880;
            4'd2:    m = 16'h0888;
            4'd3:    m = 16'h2888;
            4'd4:    m = 16'h288A;
            4'd5:    m = 16'h2A8A;
            4'd6:    m = 16'h2AAA;
            4'd7:    m = 16'hAAAA;
            4'd8:    m = 16'hAAEA;
            4'd9:    m = 16'hBAEA;
            4'd10:   m = 16'hBAEB;
            4'd11:   m = 16'hBBEB;
            4'd12:   m = 16'hBBEF;
            4'd13:   m = 16'hFBEF;
            4'd14:   m = 16'hFBFF;
            default: m = 16'hFFFF;
        endcase
        return m;
    endfunction

    assign pipe_chain = pipe_q[XW+4];
    assign pipe_hs    = pipe_q[XW+3:XW];
    assign pipe_x     = pipe_q[XW-1:0];

    // Chained sprites start right after the previous sprite's written width.
    assign load_xpos  = pipe_chain ? (prev_x + prev_w) : pipe_x;

    assign keep_mask  = shrink_mask(pipe_hs);
    assign keep_bit   = keep_mask[4'd15 - 4'(idx)];
    assign last_idx   = (idx == IW'(NPIX - 1));

    // A pixel is processed only on an enabled RUN cycle that is not being aborted.
    assign pix_step   = (state == S_RUN) && CLK_EN_PIX && !NEW_LINE;
    assign pix_we     = pix_step && keep_bit;

    assign BUSY         = (state != S_IDLE);
    assign XPOS         = xpos_q;
    assign LOAD_ERR     = load_err_q;
    assign STATE_DBG    = state;
    assign bus.PIX_WE   = pix_we;
    assign bus.PIX_ADDR = pix_we ? addr : '0;
    assign bus.PIX_IDX  = pix_we ? 4'(idx) : 4'd0;
    assign bus.DONE     = done_q;

    // State register.
    always_ff @(posedge CLK) begin
        if (!RESETP) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; NEW_LINE aborts any sprite in flight.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (bus.SPR_LOAD) begin
                    state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                state_next = S_RUN;
            end
            S_RUN: begin
                if (pix_step && last_idx) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        if (NEW_LINE && (state != S_IDLE)) begin
            state_next = S_IDLE;
        end
    end

    // Sprite datapath: parameter latch, X resolution, pixel walk, chain history.
    always_ff @(posedge CLK) begin
        if (!RESETP) begin
            pipe_q <= '0;
            prev_x <= '0;
            prev_w <= '0;
            addr   <= '0;
            xpos_q <= '0;
            idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.SPR_LOAD) begin
                        pipe_q <= bus.PIPE_C;
                    end
                end
                S_LOAD: begin
                    if (!NEW_LINE) begin
                        xpos_q <= load_xpos;
                        prev_x <= load_xpos;
                        prev_w <= {{(XW-5){1'b0}}, ({1'b0, pipe_hs} + 5'd1)};
                        addr   <= load_xpos;
                        idx    <= '0;
                    end
                end
                S_RUN: begin
                    if (pix_step) begin
                        idx <= idx + IW'(1);
                        if (keep_bit) begin
                            addr <= addr + XW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
            // Line start wipes chain history; a same-cycle load then sees it cleared.
            if (NEW_LINE) begin
                prev_x <= '0;
                prev_w <= '0;
            end
        end
    end

    // DONE pulse and sticky load-while-busy error flag.
    always_ff @(posedge CLK) begin
        if (!RESETP) begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q <= pix_step && last_idx;
            if (NEW_LINE) begin
                load_err_q <= 1'b0;
            end else if (bus.SPR_LOAD && BUSY) begin
                load_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sprite_hshrink_writer.sv
// Directed bench for sprite_hshrink_writer: reset values, shrink patterns,
// chaining with wrap, load-while-busy, line abort, pixel enable gating, reset mid-run.
module tb_sprite_hshrink_writer;

    logic       CLK;
    logic       RESETP;
    logic       CLK_EN_PIX;
    logic       NEW_LINE;
    logic       BUSY;
    logic [8:0] XPOS;
    logic       LOAD_ERR;
    logic [1:0] STATE_DBG;

    sprite_hshrink_writer_if #(.XW(9)) bus ();

    sprite_hshrink_writer #(.XW(9), .NPIX(16)) dut (
        .CLK        (CLK),
        .RESETP     (RESETP),
        .CLK_EN_PIX (CLK_EN_PIX),
        .NEW_LINE   (NEW_LINE),
        .bus        (bus),
        .BUSY       (BUSY),
        .XPOS       (XPOS),
        .LOAD_ERR   (LOAD_ERR),
        .STATE_DBG  (STATE_DBG)
    );

    // ---------------- clock / reset ----------------
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_err = 0;
    logic [12:0] exp_q[$];           // {addr, idx} of each expected write
    logic [12:0] last_pix;
    logic [15:0] mask_tbl [16];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        bus.SPR_LOAD = 1'b0;
        bus.PIPE_C   = '0;
        CLK_EN_PIX   = 1'b0;
        NEW_LINE     = 1'b0;
    endtask

    // Loads one sprite and runs it to DONE with CLK_EN_PIX high on every
    // en_period-th RUN cycle, checking each write against the expected queue.
    task automatic run_sprite(input logic ch, input logic [3:0] hs, input logic [8:0] x,
                              input logic [8:0] exp_x, input int en_period,
                              input logic nl, input string tag);
        logic [8:0] a;
        logic       en;
        int         t, enables, cycles, bad, writes;
        a = exp_x;
        for (int i = 0; i < 16; i++) begin
            if (mask_tbl[hs][15-i]) begin
                exp_q.push_back({a, 4'(i)});
                a = a + 9'd1;
            end
        end
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b1;
        bus.PIPE_C   = {ch, hs, x};
        NEW_LINE     = nl;
        CLK_EN_PIX   = 1'b0;
        t = cyc;
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b0;
        NEW_LINE     = 1'b0;
        @(negedge CLK);
        check({tag, " busy in load"}, BUSY, 1);
        enables = 0; cycles = 0; bad = 0; writes = 0;
        while (enables < 16 && cycles < 200) begin
            @(posedge CLK); #1;
            en = ((cycles % en_period) == 0);
            CLK_EN_PIX = en;
            cycles++;
            @(negedge CLK);
            if (cycles == 1) check({tag, " xpos"}, XPOS, exp_x);
            if (bus.DONE) bad++;
            if (bus.PIX_WE) begin
                writes++;
                last_pix = {bus.PIX_ADDR, bus.PIX_IDX};
                if (!en || exp_q.size() == 0) bad++;
                else check({tag, " write addr/idx"}, {bus.PIX_ADDR, bus.PIX_IDX}, exp_q.pop_front());
            end
            if (en) enables++;
        end
        check({tag, " enables before bound"}, enables, 16);
        @(posedge CLK); #1;
        CLK_EN_PIX = 1'b0;
        @(negedge CLK);
        check({tag, " done"}, bus.DONE, 1);
        check({tag, " idle after done"}, BUSY, 0);
        if (en_period == 1) check({tag, " done latency"}, cyc - t, 18);
        check({tag, " write count"}, writes, 32'(hs) + 1);
        check({tag, " stray writes/done"}, bad, 0);
        check({tag, " queue drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    // ---------------- stimulus ----------------
    int         writes, bad;
    logic [8:0] last_addr;

    initial begin
        mask_tbl = '{16'h0080, 16'h0880, 16'h0888, 16'h2888, 16'h288A, 16'h2A8A, 16'h2AAA, 16'hAAAA,
                     16'hAAEA, 16'hBAEA, 16'hBAEB, 16'hBBEB, 16'hBBEF, 16'hFBEF, 16'hFBFF, 16'hFFFF};
        drive_idle();
        RESETP = 1'b0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        check("reset busy", BUSY, 0);
        check("reset xpos", XPOS, 0);
        check("reset we", bus.PIX_WE, 0);
        check("reset done", bus.DONE, 0);
        check("reset load_err", LOAD_ERR, 0);
        check("reset state", STATE_DBG, 0);
        @(posedge CLK); #1;
        RESETP = 1'b1;

        // 1: full-width sprite, no chaining
        run_sprite(1'b0, 4'd15, 9'd100, 9'd100, 1, 1'b0, "t1");
        check("t1 last write", last_pix, {9'd115, 4'd15});

        // 2: narrowest and half shrink
        run_sprite(1'b0, 4'd0, 9'd20, 9'd20, 1, 1'b0, "t2 hs0");
        check("t2 hs0 single idx", last_pix, {9'd20, 4'd8});
        run_sprite(1'b0, 4'd7, 9'd40, 9'd40, 1, 1'b0, "t2 hs7");
        check("t2 hs7 last write", last_pix, {9'd47, 4'd14});

        // 3: wrap through 511 -> 0, then chained sprite resolves to 516 mod 512
        run_sprite(1'b0, 4'd15, 9'd500, 9'd500, 1, 1'b0, "t3 A");
        check("t3 A wrapped last", last_pix, {9'd3, 4'd15});
        run_sprite(1'b1, 4'd3, 9'd300, 9'd4, 1, 1'b0, "t3 B");
        check("t3 B last write", last_pix, {9'd7, 4'd12});

        // NEW_LINE with SPR_LOAD in the same cycle: chain sees cleared history
        run_sprite(1'b1, 4'd1, 9'd250, 9'd0, 1, 1'b1, "nl+load");

        // 4: load while busy, then abort mid-run
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b1;
        bus.PIPE_C   = {1'b0, 4'd15, 9'd10};
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b0;
        writes = 0; bad = 0; last_addr = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge CLK); #1;
            CLK_EN_PIX   = 1'b1;
            bus.SPR_LOAD = (c == 3);
            bus.PIPE_C   = {1'b0, 4'd0, 9'd200};
            NEW_LINE     = (c == 6);
            @(negedge CLK);
            if (bus.PIX_WE) begin
                writes++;
                last_addr = bus.PIX_ADDR;
            end
            if (c == 4) check("t4 load_err set", LOAD_ERR, 1);
            if (c == 6) check("t4 we low on new_line", bus.PIX_WE, 0);
        end
        @(posedge CLK); #1;
        NEW_LINE     = 1'b0;
        bus.SPR_LOAD = 1'b0;
        @(negedge CLK);
        check("t4 aborted to idle", BUSY, 0);
        check("t4 load_err cleared", LOAD_ERR, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            if (bus.DONE || bus.PIX_WE) bad++;
        end
        check("t4 no done/writes after abort", bad, 0);
        check("t4 write count", writes, 5);
        check("t4 last addr", last_addr, 14);
        CLK_EN_PIX = 1'b0;
        run_sprite(1'b1, 4'd2, 9'd77, 9'd0, 1, 1'b0, "t4 chain");
        check("t4 chain last write", last_pix, {9'd2, 4'd12});

        // 5: pixel enable 1-of-4
        run_sprite(1'b0, 4'd15, 9'd300, 9'd300, 4, 1'b0, "t5");

        // 6: reset in the middle of RUN
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b1;
        bus.PIPE_C   = {1'b0, 4'd15, 9'd50};
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            @(posedge CLK); #1;
            CLK_EN_PIX   = 1'b1;
            bus.SPR_LOAD = (c == 2);
            @(negedge CLK);
            if (c == 3) check("t6 load_err before reset", LOAD_ERR, 1);
        end
        @(posedge CLK); #1;
        bus.SPR_LOAD = 1'b0;
        RESETP       = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check("t6 busy", BUSY, 0);
        check("t6 xpos", XPOS, 0);
        check("t6 we", bus.PIX_WE, 0);
        check("t6 addr", bus.PIX_ADDR, 0);
        check("t6 idx", bus.PIX_IDX, 0);
        check("t6 done", bus.DONE, 0);
        check("t6 load_err", LOAD_ERR, 0);
        @(posedge CLK); #1;
        RESETP     = 1'b1;
        CLK_EN_PIX = 1'b0;
        run_sprite(1'b0, 4'd15, 9'd100, 9'd100, 1, 1'b0, "t6 reload");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
